// File: rtl/routine_scheduler_pkg.sv
// rtl/routine_scheduler_pkg.sv - shared types and bus field layout for the routine scheduler
package routine_scheduler_pkg;

    localparam int NUM_RTN  = 4;
    localparam int RTN_W    = 2;
    localparam int BUS_W    = 47;
    localparam int DONE_BIT = 46;
    localparam int RED_HI   = 45;
    localparam int RED_LO   = 36;
    localparam int GRN_HI   = 35;
    localparam int GRN_LO   = 28;
    localparam int HEX_LO   = 0;
    localparam int HEX_W    = 7;
    localparam int RED_W    = RED_HI - RED_LO + 1;
    localparam int GRN_W    = GRN_HI - GRN_LO + 1;

    // Seven-segment digits are active-low, so all-ones is a dark digit.
    localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    function automatic logic [HEX_W-1:0] hex_digit(input logic [BUS_W-1:0] bus, input int n);
        return bus[HEX_LO + n*HEX_W +: HEX_W];
    endfunction

endpackage

// File: rtl/routine_scheduler_if.sv
// rtl/routine_scheduler_if.sv - routine buses, control inputs and display/status outputs
interface routine_scheduler_if;
    import routine_scheduler_pkg::*;

    logic [BUS_W-1:0]   Bus0;
    logic [BUS_W-1:0]   Bus1;
    logic [BUS_W-1:0]   Bus2;
    logic [BUS_W-1:0]   Bus3;
    logic [NUM_RTN-1:0] Enable;
    logic               Mode;
    logic [RTN_W-1:0]   Select;
    logic               NextBtn;
    logic [NUM_RTN-1:0] RtnReset;
    logic [RTN_W-1:0]   ActiveRtn;
    logic               Running;
    logic [RED_W-1:0]   LedRed;
    logic [GRN_W-1:0]   LedGrn;
    logic [HEX_W-1:0]   Hex3;
    logic [HEX_W-1:0]   Hex2;
    logic [HEX_W-1:0]   Hex1;
    logic [HEX_W-1:0]   Hex0;

    modport master (
        output Bus0, Bus1, Bus2, Bus3, Enable, Mode, Select, NextBtn,
        input  RtnReset, ActiveRtn, Running, LedRed, LedGrn, Hex3, Hex2, Hex1, Hex0
    );

    modport slave (
        input  Bus0, Bus1, Bus2, Bus3, Enable, Mode, Select, NextBtn,
        output RtnReset, ActiveRtn, Running, LedRed, LedGrn, Hex3, Hex2, Hex1, Hex0
    );

endinterface

// File: rtl/routine_scheduler_rr_next_enabled.sv
// rtl/routine_scheduler_rr_next_enabled.sv - round-robin search for the next enabled routine after cur
module rr_next_enabled
    import routine_scheduler_pkg::*;
(
    input  logic [RTN_W-1:0]   cur,
    input  logic [NUM_RTN-1:0] mask,
    output logic [RTN_W-1:0]   nxt
);

    logic [RTN_W-1:0] idx;

    // Scan farthest offset first so the nearest enabled index wins; offset 4
    // wraps back to cur, which relaunches a lone enabled routine.
    always_comb begin
        nxt = cur;
        idx = '0;
        for (int k = NUM_RTN; k >= 1; k--) begin
            idx = cur + RTN_W'(k);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
    end

endmodule

// File: rtl/routine_scheduler.sv
// rtl/routine_scheduler.sv - sequences four display routines with blanking, watchdog and manual override
module routine_scheduler
    import routine_scheduler_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic               Clock,
    input  logic               Reset,
    routine_scheduler_if.slave sif
);

    localparam logic [15:0] WDOG_LAST  = 16'(WDOG_CYCLES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [RTN_W-1:0]   active_rtn;
    logic [RTN_W-1:0]   target;
    logic [15:0]        wdog_cnt;
    logic [7:0]         blank_cnt;
    logic               nextbtn_q;
    logic [BUS_W-1:0]   bus_sel;
    logic [RTN_W-1:0]   rr_from_active;
    logic [RTN_W-1:0]   rr_lowest;
    logic [NUM_RTN-1:0] rtn_reset;
    logic               running;
    logic [RED_W-1:0]   led_red;
    logic [GRN_W-1:0]   led_grn;
    logic [HEX_W-1:0]   hex3, hex2, hex1, hex0;
    logic               ev_dis, ev_sel, ev_btn, ev_done, ev_wdog, run_exit, blank_last;

    rr_next_enabled u_rr_active (.cur(active_rtn), .mask(sif.Enable), .nxt(rr_from_active));

    // Searching onward from index 3 yields the lowest enabled index.
    rr_next_enabled u_rr_lowest (.cur(2'd3), .mask(sif.Enable), .nxt(rr_lowest));

    always_comb begin
        case (active_rtn)
            2'd0:    bus_sel = sif.Bus0;
            2'd1:    bus_sel = sif.Bus1;
            2'd2:    bus_sel = sif.Bus2;
            default: bus_sel = sif.Bus3;
        endcase
    end

    // wdog_cnt is zero only in the first RUN cycle, where done may be stale.
    assign ev_dis     = !sif.Enable[active_rtn];
    assign ev_sel     = sif.Mode && (sif.Select != active_rtn) && sif.Enable[sif.Select];
    assign ev_btn     = sif.NextBtn && !nextbtn_q;
    assign ev_done    = !sif.Mode && (wdog_cnt != 16'd0) && bus_sel[DONE_BIT];
    assign ev_wdog    = (wdog_cnt == WDOG_LAST);
    assign run_exit   = ev_dis || ev_sel || ev_btn || ev_done || ev_wdog;
    assign blank_last = (blank_cnt == BLANK_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|sif.Enable) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_RUN;
            ST_RUN:    if (run_exit) state_nxt = ST_BLANK;
            ST_BLANK:  if (blank_last) state_nxt = (|sif.Enable) ? ST_LAUNCH : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rtn_reset = '1;
        running   = 1'b0;
        if (state == ST_RUN) begin
            rtn_reset = ~(4'b0001 << active_rtn);
            running   = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            active_rtn <= '0;
            target     <= '0;
            wdog_cnt   <= '0;
            blank_cnt  <= '0;
            nextbtn_q  <= 1'b0;
            led_red    <= '0;
            led_grn    <= '0;
            hex3       <= HEX_BLANK;
            hex2       <= HEX_BLANK;
            hex1       <= HEX_BLANK;
            hex0       <= HEX_BLANK;
        end else begin
            nextbtn_q <= sif.NextBtn;
            case (state)
                ST_IDLE: target <= rr_lowest;
                ST_LAUNCH: begin
                    active_rtn <= target;
                    wdog_cnt   <= '0;
                end
                ST_RUN: begin
                    wdog_cnt  <= wdog_cnt + 16'd1;
                    blank_cnt <= '0;
                    // A disable outranks a manual Select, so it falls back to round-robin.
                    if (run_exit) begin
                        target <= (!ev_dis && ev_sel) ? sif.Select : rr_from_active;
                    end
                end
                default: blank_cnt <= blank_cnt + 8'd1;
            endcase

            // Load only while staying in RUN so the first BLANK cycle is already dark.
            if (state == ST_RUN && state_nxt == ST_RUN) begin
                led_red <= bus_sel[RED_HI:RED_LO];
                led_grn <= bus_sel[GRN_HI:GRN_LO];
                hex3    <= hex_digit(bus_sel, 3);
                hex2    <= hex_digit(bus_sel, 2);
                hex1    <= hex_digit(bus_sel, 1);
                hex0    <= hex_digit(bus_sel, 0);
            end else begin
                led_red <= '0;
                led_grn <= '0;
                hex3    <= HEX_BLANK;
                hex2    <= HEX_BLANK;
                hex1    <= HEX_BLANK;
                hex0    <= HEX_BLANK;
            end
        end
    end

    assign sif.RtnReset  = rtn_reset;
    assign sif.ActiveRtn = active_rtn;
    assign sif.Running   = running;
    assign sif.LedRed    = led_red;
    assign sif.LedGrn    = led_grn;
    assign sif.Hex3      = hex3;
    assign sif.Hex2      = hex2;
    assign sif.Hex1      = hex1;
    assign sif.Hex0      = hex0;

endmodule

// File: doc/routine_scheduler.md
ROUTINE_SCHEDULER -- requirements
Module: routine_scheduler

Interface
REQ-001 Parameter BLANK_CYCLES, default 2, SHALL set the number of blank cycles between routines (legal range 1..255).
REQ-002 Parameter WDOG_CYCLES, default 1024, SHALL set the maximum RUN dwell before a forced advance (legal range 2..65535).
REQ-003 Clock  input  1  SHALL be the single clock; every register is updated on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Bus0..Bus3  input  47 each  SHALL be routine buses: [46] done pulse, [45:36] red, [35:28] green, [27:0] Hex3..Hex0.
REQ-006 Enable  input  4  SHALL be the per-routine enable mask, bit n for routine n.
REQ-007 Mode  input  1  SHALL select the mode: 0 auto (advance on done), 1 manual.
REQ-008 Select  input  2  SHALL give the manual target routine.
REQ-009 NextBtn  input  1  SHALL be a pre-synchronized level; its rising edge requests an advance.
REQ-010 RtnReset  output  4  SHALL hold routine n in reset while bit n is 1.
REQ-011 ActiveRtn  output  2  SHALL give the index of the current or last routine.
REQ-012 Running  output  1  SHALL be 1 only in RUN.
REQ-013 LedRed  output  10, LedGrn  output  8, Hex3..Hex0  output  7 each  SHALL be the registered display outputs.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LAUNCH, RUN and BLANK.
REQ-015 In IDLE, the block SHALL pick the lowest enabled index; if Enable==0 it SHALL stay in IDLE, else go to LAUNCH.
REQ-016 LAUNCH SHALL last 1 cycle: RtnReset = all-ones except the target bit = 1 for this cycle; ActiveRtn <= target; next state RUN.
REQ-017 In RUN, RtnReset SHALL be all-ones except bit ActiveRtn = 0.
REQ-018 In RUN, outputs SHALL equal the selected Bus fields, registered with 1 cycle of latency.
REQ-019 RUN SHALL exit to BLANK on the first of these events: auto-mode done; NextBtn rising edge; manual-mode Select != ActiveRtn while Select is enabled; the Enable bit for ActiveRtn dropping to 0; watchdog count == WDOG_CYCLES-1.
REQ-020 The done bit [46] SHALL be ignored in the first RUN cycle (guard against stale reset values) and SHALL be ignored in manual mode.
REQ-021 The watchdog counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-022 The next target SHALL be computed on RUN exit. In auto mode, or on NextBtn/watchdog, it SHALL be round-robin from ActiveRtn+1 mod 4, skipping disabled routines; with a single routine enabled it SHALL relaunch that same routine.
REQ-023 On a manual-mode Select change, the next target SHALL be Select.
REQ-024 BLANK SHALL last exactly BLANK_CYCLES cycles, with RtnReset = 4'b1111, LED outputs = 0, Hex outputs = 7'h7F (active-low off), then go to LAUNCH.
REQ-025 If Enable becomes 0 during BLANK, the FSM SHALL go to IDLE at BLANK end.
REQ-026 Simultaneous RUN-exit events SHALL produce a single transition, with priority: disable > manual Select > NextBtn > done > watchdog.
REQ-027 The NextBtn edge detector SHALL update every cycle; edges outside RUN SHALL be discarded.
REQ-028 Displays SHALL be blank in IDLE and LAUNCH.

Reset
REQ-029 On Reset, the block SHALL set state=IDLE, ActiveRtn=0, RtnReset=4'b1111, Running=0, LEDs=0, Hex=7'h7F, and clear the watchdog, blank counter and NextBtn history.
REQ-030 Reset SHALL take priority over any event in the same cycle, including mid-RUN.

Structure
REQ-031 A shared package SHALL hold the state enum, the bus field offsets (DONE_BIT=46, RED_HI/LO, GRN_HI/LO, HEX_LO), HEX_BLANK=7'h7F and the routine count 4.
REQ-032 A single sub-module, rr_next_enabled, SHALL hold the combinational round-robin next-enabled-index finder (inputs: current index, mask).

Verification
REQ-033 Enable=4'b1111, Mode=0, Bus1[46] pulsed 1 cycle in RUN -> BLANK for 2 cycles, LAUNCH, then ActiveRtn=2 and RtnReset=4'b1011.
REQ-034 Enable=4'b0101, ActiveRtn=0, done -> next ActiveRtn=2; done again -> ActiveRtn=0 (bits 1 and 3 skipped).
REQ-035 Mode=1, Select changed 0->3 with Enable=4'b1111 -> exit the following cycle, ActiveRtn=3 after BLANK+LAUNCH; done pulses on Bus3 ignored.
REQ-036 WDOG_CYCLES=8, no done -> RUN exit exactly 8 cycles after RUN entry.
REQ-037 Reset asserted mid-RUN -> the next cycle shows IDLE, RtnReset=4'b1111, Hex=7'h7F, LEDs=0.
REQ-038 Enable=0 after reset -> the FSM stays in IDLE indefinitely; Enable set to 4'b1000 -> LAUNCH, then ActiveRtn=3.
